// File: rtl/i2c_target_regfile.sv
// I2C target responder with an 8-byte register file.
// Bus pins are oversampled in the system clock domain. Writes are pointer-then-data
// with auto-increment. Reads return mem[ptr] and auto-increment on each master ACK.
// A local host port reads combinationally and writes synchronously.
module i2c_target_regfile #(
    parameter logic [6:0] SLV_ADR = 7'h2A
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       scl_pad_i,
    output logic       scl_pad_o,
    output logic       scl_padoen_o,
    input  logic       sda_pad_i,
    output logic       sda_pad_o,
    output logic       sda_padoen_o,
    input  logic [2:0] lcl_adr_i,
    output logic [7:0] lcl_dat_o,
    input  logic       lcl_we_i,
    input  logic [7:0] lcl_dat_i,
    output logic       busy_o,
    output logic       wr_evt_o
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_WAIT
    } state_t;

    // Synchronizer chain: two metastability stages plus a previous-value stage.
    logic [1:0] scl_sync_reg;
    logic [1:0] sda_sync_reg;
    logic       scl_prev_reg;
    logic       sda_prev_reg;

    logic scl_s;
    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;
    logic [7:0] rx_byte;

    state_t     state_reg, state_next;
    logic [3:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0] shift_reg, shift_next;
    logic [2:0] ptr_reg, ptr_next;
    logic       rw_reg, rw_next;
    logic       sda_oen_reg, sda_oen_next;
    logic       busy_reg, busy_next;
    logic       wr_evt_reg, wr_evt_next;

    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_word [8];

    // No clock stretching and open-drain SDA: only the enable ever moves.
    assign scl_pad_o    = 1'b0;
    assign scl_padoen_o = 1'b1;
    assign sda_pad_o    = 1'b0;
    assign sda_padoen_o = sda_oen_reg;
    assign busy_o       = busy_reg;
    assign wr_evt_o     = wr_evt_reg;
    assign lcl_dat_o    = mem_word[lcl_adr_i];

    // Pin synchronizers; left free-running through reset so that they track the real
    // bus and no false edge (or false START) is seen when reset is released.
    always_ff @(posedge wb_clk_i) begin
        scl_sync_reg <= {scl_sync_reg[0], scl_pad_i};
        sda_sync_reg <= {sda_sync_reg[0], sda_pad_i};
        scl_prev_reg <= scl_sync_reg[1];
        sda_prev_reg <= sda_sync_reg[1];
    end

    assign scl_s     = scl_sync_reg[1];
    assign sda_s     = sda_sync_reg[1];
    assign scl_rise  = scl_s & ~scl_prev_reg;
    assign scl_fall  = ~scl_s & scl_prev_reg;
    // SCL must be high in both the current and previous sample for a bus condition.
    assign start_det = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
    assign stop_det  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;
    assign rx_byte   = {shift_reg[6:0], sda_s};

    // Protocol state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= 4'd0;
            shift_reg   <= 8'd0;
            ptr_reg     <= 3'd0;
            rw_reg      <= 1'b0;
            sda_oen_reg <= 1'b1;
            busy_reg    <= 1'b0;
            wr_evt_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            ptr_reg     <= ptr_next;
            rw_reg      <= rw_next;
            sda_oen_reg <= sda_oen_next;
            busy_reg    <= busy_next;
            wr_evt_reg  <= wr_evt_next;
        end
    end

    // Next-state logic: START/STOP take priority over bit events. In the ACK states
    // sda_oen_reg tells the first SCL fall (begin ACK drive) from the second (end ACK).
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        ptr_next     = ptr_reg;
        rw_next      = rw_reg;
        sda_oen_next = sda_oen_reg;
        busy_next    = busy_reg;
        wr_evt_next  = 1'b0;
        mem_we       = 1'b0;
        mem_wdata    = rx_byte;

        if (start_det) begin
            state_next   = ST_ADDR;
            bit_cnt_next = 4'd0;
            sda_oen_next = 1'b1;
        end else if (stop_det) begin
            state_next   = ST_IDLE;
            sda_oen_next = 1'b1;
            busy_next    = 1'b0;
        end else begin
            case (state_reg)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_next   = rx_byte;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            bit_cnt_next = 4'd0;
                            if (rx_byte[7:1] == SLV_ADR) begin
                                state_next = ST_ADDR_ACK;
                                rw_next    = rx_byte[0];
                            end else begin
                                state_next = ST_WAIT;
                                busy_next  = 1'b0;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (sda_oen_reg) begin
                            sda_oen_next = 1'b0;
                            busy_next    = 1'b1;
                        end else if (rw_reg) begin
                            state_next   = ST_RDATA;
                            shift_next   = mem_word[ptr_reg];
                            sda_oen_next = mem_word[ptr_reg][7];
                            bit_cnt_next = 4'd1;
                        end else begin
                            state_next   = ST_PTR;
                            sda_oen_next = 1'b1;
                            bit_cnt_next = 4'd0;
                        end
                    end
                end
                ST_PTR: begin
                    if (scl_rise) begin
                        shift_next   = rx_byte;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            bit_cnt_next = 4'd0;
                            ptr_next     = rx_byte[2:0];
                            state_next   = ST_PTR_ACK;
                        end
                    end
                end
                ST_WDATA: begin
                    if (scl_rise) begin
                        shift_next   = rx_byte;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (bit_cnt_reg == 4'd7) begin
                            bit_cnt_next = 4'd0;
                            mem_we       = 1'b1;
                            wr_evt_next  = 1'b1;
                            ptr_next     = ptr_reg + 3'd1;
                            state_next   = ST_WDATA_ACK;
                        end
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        if (sda_oen_reg) begin
                            sda_oen_next = 1'b0;
                        end else begin
                            state_next   = ST_WDATA;
                            sda_oen_next = 1'b1;
                            bit_cnt_next = 4'd0;
                        end
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_reg == 4'd8) begin
                            state_next   = ST_RDATA_ACK;
                            sda_oen_next = 1'b1;
                        end else begin
                            sda_oen_next = shift_reg[6];
                            shift_next   = {shift_reg[6:0], 1'b0};
                            bit_cnt_next = bit_cnt_reg + 4'd1;
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise && bit_cnt_reg == 4'd8) begin
                        if (!sda_s) begin
                            ptr_next     = ptr_reg + 3'd1;
                            bit_cnt_next = 4'd9;
                        end else begin
                            state_next   = ST_WAIT;
                            sda_oen_next = 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_reg == 4'd9) begin
                        state_next   = ST_RDATA;
                        shift_next   = mem_word[ptr_reg];
                        sda_oen_next = mem_word[ptr_reg][7];
                        bit_cnt_next = 4'd1;
                    end
                end
                default: begin
                    // IDLE and WAIT only react to START/STOP.
                end
            endcase
        end
    end

    // Register file: one byte register per index; the I2C write wins a same-index collision.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_mem
            localparam logic [2:0] IDX = 3'(gi);
            logic [7:0] byte_reg;

            // Byte storage with reset clear, I2C write first, local write second.
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    byte_reg <= 8'd0;
                end else if (mem_we && ptr_reg == IDX) begin
                    byte_reg <= mem_wdata;
                end else if (lcl_we_i && lcl_adr_i == IDX) begin
                    byte_reg <= lcl_dat_i;
                end
            end

            assign mem_word[gi] = byte_reg;
        end
    endgenerate

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master, expected-response queue,
// and an independent bus/register-write monitor that pops and compares.
module tb_i2c_target_regfile;

    logic       clk = 1'b0;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       scl_bus;
    logic       sda_bus;
    logic       scl_pad_o;
    logic       scl_padoen_o;
    logic       sda_pad_o;
    logic       sda_padoen_o;
    logic [2:0] lcl_adr;
    logic [7:0] lcl_dat_o;
    logic       lcl_we;
    logic [7:0] lcl_dat_i;
    logic       busy_o;
    logic       wr_evt_o;

    always #5 clk = ~clk;

    // Open-drain bus: master and target both only pull low.
    assign scl_bus = scl_m & (scl_padoen_o | scl_pad_o);
    assign sda_bus = sda_m & (sda_padoen_o | sda_pad_o);

    i2c_target_regfile #(.SLV_ADR(7'h2A)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (rst),
        .scl_pad_i    (scl_bus),
        .scl_pad_o    (scl_pad_o),
        .scl_padoen_o (scl_padoen_o),
        .sda_pad_i    (sda_bus),
        .sda_pad_o    (sda_pad_o),
        .sda_padoen_o (sda_padoen_o),
        .lcl_adr_i    (lcl_adr),
        .lcl_dat_o    (lcl_dat_o),
        .lcl_we_i     (lcl_we),
        .lcl_dat_i    (lcl_dat_i),
        .busy_o       (busy_o),
        .wr_evt_o     (wr_evt_o)
    );

    typedef struct packed {
        logic       is_wr;
        logic [2:0] idx;
        logic [7:0] data;
        logic       ack;
    } exp_t;

    exp_t       exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] model_mem [8];
    logic       drive_seen;
    logic       busy_seen;

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [7:0] b, input logic a);
        exp_t e;
        e.is_wr = 1'b0;
        e.idx   = 3'd0;
        e.data  = b;
        e.ack   = a;
        exp_q.push_back(e);
    endtask

    task automatic push_wr(input logic [2:0] idx, input logic [7:0] b);
        exp_t e;
        e.is_wr = 1'b1;
        e.idx   = idx;
        e.data  = b;
        e.ack   = 1'b0;
        exp_q.push_back(e);
        model_mem[idx] = b;
    endtask

    // One SCL clock: 10 cycles low (data set mid-low), 10 cycles high.
    task automatic send_bit(input logic b);
        wait_clk(5);
        sda_m = b;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(10);
        scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        if (!scl_m) begin
            wait_clk(5);
            sda_m = 1'b1;
            wait_clk(5);
            scl_m = 1'b1;
        end
        wait_clk(10);
        sda_m = 1'b0;
        wait_clk(10);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(5);
        sda_m = 1'b0;
        wait_clk(5);
        scl_m = 1'b1;
        wait_clk(10);
        sda_m = 1'b1;
        wait_clk(10);
    endtask

    task automatic wr_byte(input logic [7:0] b, input logic exp_ack);
        push_frame(b, exp_ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(1'b1);
    endtask

    task automatic wr_data(input logic [2:0] idx, input logic [7:0] b);
        lcl_adr = idx;
        push_wr(idx, b);
        wr_byte(b, 1'b0);
    endtask

    task automatic rd_byte(input logic [7:0] exp_b, input logic master_ack);
        push_frame(exp_b, master_ack);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        send_bit(master_ack);
    endtask

    task automatic check_all_mem(input string name);
        for (int i = 0; i < 8; i++) begin
            lcl_adr = 3'(i);
            wait_clk(1);
            check8(name, lcl_dat_o, model_mem[i]);
        end
    endtask

    // Monitor: decodes the bus independently and watches wr_evt_o, popping expectations.
    initial begin
        logic       pscl;
        logic       psda;
        int         mcnt;
        logic [7:0] mshift;
        exp_t       e;
        pscl = 1'b1;
        psda = 1'b1;
        mcnt = 0;
        mshift = 8'd0;
        forever begin
            @(negedge clk);
            if (sda_padoen_o === 1'b0) drive_seen = 1'b1;
            if (busy_o === 1'b1) busy_seen = 1'b1;
            if (wr_evt_o === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wr_evt: unexpected pulse, lcl_dat_o=%h, nothing expected", lcl_dat_o);
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_wr || lcl_dat_o !== e.data) begin
                        n_fail++;
                        $display("FAIL wr_evt: got idx %0d data %h, expected is_wr=%b idx %0d data %h",
                                 lcl_adr, lcl_dat_o, e.is_wr, e.idx, e.data);
                    end else begin
                        $display("reg write idx=%0d data=%h", e.idx, lcl_dat_o);
                    end
                end
            end
            if (scl_bus && pscl && psda && !sda_bus) begin
                mcnt = 0;
            end else if (scl_bus && pscl && !psda && sda_bus) begin
                mcnt = 0;
            end else if (scl_bus && !pscl) begin
                if (mcnt < 8) begin
                    mshift = {mshift[6:0], sda_bus};
                    mcnt++;
                end else begin
                    mcnt = 0;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL frame: got byte %h ack %b, nothing expected", mshift, sda_bus);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_wr || mshift !== e.data || sda_bus !== e.ack) begin
                            n_fail++;
                            $display("FAIL frame: got byte %h ack %b, expected is_wr=%b byte %h ack %b",
                                     mshift, sda_bus, e.is_wr, e.data, e.ack);
                        end else begin
                            $display("frame byte=%h ack=%b", mshift, sda_bus);
                        end
                    end
                end
            end
            pscl = scl_bus;
            psda = sda_bus;
        end
    end

    // Watchdog: stimulus is time-driven, so this only fires on a simulator problem.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        scl_m      = 1'b1;
        sda_m      = 1'b1;
        lcl_adr    = 3'd0;
        lcl_we     = 1'b0;
        lcl_dat_i  = 8'd0;
        drive_seen = 1'b0;
        busy_seen  = 1'b0;
        for (int i = 0; i < 8; i++) model_mem[i] = 8'd0;
        wait_clk(10);
        rst = 1'b0;
        wait_clk(2);

        $display("txn: reset state");
        check8("reset sda_padoen_o", {7'd0, sda_padoen_o}, 8'd1);
        check8("reset scl_padoen_o", {7'd0, scl_padoen_o}, 8'd1);
        check8("reset busy_o", {7'd0, busy_o}, 8'd0);
        check8("reset wr_evt_o", {7'd0, wr_evt_o}, 8'd0);
        check_all_mem("reset mem");

        $display("txn: write ptr 3, A5 5A");
        i2c_start();
        wr_byte(8'h54, 1'b0);
        check8("busy after addr ack", {7'd0, busy_o}, 8'd1);
        wr_byte(8'h03, 1'b0);
        wr_data(3'd3, 8'hA5);
        wr_data(3'd4, 8'h5A);
        i2c_stop();
        check8("busy after stop", {7'd0, busy_o}, 8'd0);

        $display("txn: pointer wrap 7 -> 0");
        i2c_start();
        wr_byte(8'h54, 1'b0);
        wr_byte(8'h07, 1'b0);
        wr_data(3'd7, 8'h11);
        wr_data(3'd0, 8'h22);
        i2c_stop();

        $display("txn: ptr 0x0E selects index 6");
        i2c_start();
        wr_byte(8'h54, 1'b0);
        wr_byte(8'h0E, 1'b0);
        wr_data(3'd6, 8'h66);
        i2c_stop();

        $display("txn: read from 6 with repeated start");
        i2c_start();
        wr_byte(8'h54, 1'b0);
        wr_byte(8'h06, 1'b0);
        i2c_start();
        wr_byte(8'h55, 1'b0);
        rd_byte(8'h66, 1'b0);
        rd_byte(8'h11, 1'b0);
        rd_byte(8'h22, 1'b1);
        wait_clk(6);
        check8("released after nack", {7'd0, sda_padoen_o}, 8'd1);
        i2c_stop();
        check8("busy after read stop", {7'd0, busy_o}, 8'd0);

        $display("txn: address mismatch 0x2B");
        drive_seen = 1'b0;
        busy_seen  = 1'b0;
        i2c_start();
        wr_byte(8'h56, 1'b1);
        wr_byte(8'hFF, 1'b1);
        i2c_stop();
        check8("mismatch sda driven", {7'd0, drive_seen}, 8'd0);
        check8("mismatch busy seen", {7'd0, busy_seen}, 8'd0);
        check_all_mem("mismatch mem");

        $display("txn: stop after 4 data bits");
        i2c_start();
        wr_byte(8'h54, 1'b0);
        wr_byte(8'h02, 1'b0);
        lcl_adr = 3'd2;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        i2c_stop();
        check8("busy after mid-byte stop", {7'd0, busy_o}, 8'd0);
        check8("no write on mid-byte stop", lcl_dat_o, 8'h00);

        $display("txn: normal write after aborted byte");
        i2c_start();
        wr_byte(8'h54, 1'b0);
        wr_byte(8'h02, 1'b0);
        wr_data(3'd2, 8'h3C);
        i2c_stop();

        $display("txn: local write idx 5");
        lcl_adr   = 3'd5;
        lcl_dat_i = 8'h99;
        lcl_we    = 1'b1;
        wait_clk(1);
        lcl_we    = 1'b0;
        model_mem[5] = 8'h99;
        check8("local write", lcl_dat_o, 8'h99);
        check_all_mem("mem before reset");

        $display("txn: reset mid-read while driving 0");
        i2c_start();
        wr_byte(8'h54, 1'b0);
        wr_byte(8'h02, 1'b0);
        i2c_start();
        wr_byte(8'h55, 1'b0);
        wait_clk(6);
        check8("read msb driven low", {7'd0, sda_padoen_o}, 8'd0);
        rst = 1'b1;
        wait_clk(1);
        check8("release on reset", {7'd0, sda_padoen_o}, 8'd1);
        wait_clk(3);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) model_mem[i] = 8'd0;
        i2c_stop();
        check8("busy after reset", {7'd0, busy_o}, 8'd0);
        check_all_mem("mem after reset");

        wait_clk(20);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got %0d pending expectations, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
